// File: rtl/counter_pkg.sv
// Shared types and helpers for the bin counter: FSM state encoding and saturation limit.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCounting,
        StDone
    } state_e;

    // All-ones value of a count register of the given width, capped at 32 bits.
    function automatic logic [31:0] sat_max(input int unsigned width);
        if (width >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/counter_gate_timer.sv
// Gate-window timer: holds the bin length and flags the last clock of every window.
module counter_gate_timer #(
    parameter int unsigned GATE_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic                  abort_i,
    input  logic                  run_i,
    input  logic [GATE_WIDTH-1:0] gate_cycles_i,
    output logic                  last_o
);

    logic [GATE_WIDTH-1:0] len_q, len_d;
    logic [GATE_WIDTH-1:0] cnt_q, cnt_d;

    assign last_o = (cnt_q == len_q - GATE_WIDTH'(1));

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (load_i) begin
            // A zero-length window behaves as a single clock.
            len_d = (gate_cycles_i == '0) ? GATE_WIDTH'(1) : gate_cycles_i;
            cnt_d = '0;
        end else if (abort_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = last_o ? '0 : cnt_q + GATE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_bin_writer.sv
// Counts pulse rising edges per gate window and writes each bin's saturated count to SRAM port A.
module counter_bin_writer
    import counter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned GATE_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [GATE_WIDTH-1:0] i_gate_cycles,
    input  logic [ADDR_WIDTH:0]   i_num_bins,
    input  logic                  i_continuous,
    input  logic                  i_pulse,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_we,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_bin_idx,
    output logic                  o_wrapped,
    output logic                  o_overflow
);

    localparam logic [DATA_WIDTH-1:0] CntMax = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [ADDR_WIDTH:0]   DepthN = (ADDR_WIDTH + 1)'(DEPTH);

    state_e                state_q, state_d;
    logic                  prev_q;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, data_q, data_d;
    logic [ADDR_WIDTH-1:0] bin_q, bin_d, addr_q, addr_d;
    logic [ADDR_WIDTH:0]   nbins_q, nbins_d;
    logic                  cont_q, cont_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;
    logic                  ovf_q, ovf_d;

    logic                  counting, pulse_edge, at_max, last_gate, last_bin;
    logic                  start_go, abort;
    logic [DATA_WIDTH-1:0] cnt_inc;

    assign counting   = (state_q == StCounting);
    assign pulse_edge = i_pulse & ~prev_q;
    assign at_max     = (cnt_q == CntMax);
    assign cnt_inc    = (pulse_edge && !at_max) ? cnt_q + DATA_WIDTH'(1) : cnt_q;
    assign last_bin   = ({1'b0, bin_q} == nbins_q - (ADDR_WIDTH + 1)'(1));
    assign start_go   = i_start && !i_stop && !counting;
    assign abort      = i_stop && counting;

    counter_gate_timer #(
        .GATE_WIDTH (GATE_WIDTH)
    ) u_gate_timer (
        .clk_i         (i_clk),
        .rst_ni        (i_rstn),
        .load_i        (start_go),
        .abort_i       (abort),
        .run_i         (counting),
        .gate_cycles_i (i_gate_cycles),
        .last_o        (last_gate)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        nbins_d = nbins_q;
        cont_d  = cont_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        wrap_d  = wrap_q;
        ovf_d   = ovf_q;
        case (state_q)
            StCounting: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else begin
                    if (pulse_edge && at_max) ovf_d = 1'b1;
                    if (last_gate) begin
                        we_d   = 1'b1;
                        addr_d = bin_q;
                        data_d = cnt_inc;
                        cnt_d  = '0;
                        if (!last_bin) begin
                            bin_d = bin_q + ADDR_WIDTH'(1);
                        end else if (cont_q) begin
                            bin_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                if (i_stop) begin
                    done_d = 1'b0;
                end else if (i_start) begin
                    state_d = StCounting;
                    if (i_num_bins == '0) begin
                        nbins_d = (ADDR_WIDTH + 1)'(1);
                    end else if (i_num_bins > DepthN) begin
                        nbins_d = DepthN;
                    end else begin
                        nbins_d = i_num_bins;
                    end
                    cont_d = i_continuous;
                    bin_d  = '0;
                    cnt_d  = '0;
                    done_d = 1'b0;
                    wrap_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= StIdle;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            bin_q   <= '0;
            nbins_q <= '0;
            cont_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= i_pulse;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            nbins_q <= nbins_d;
            cont_q  <= cont_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_sram_addr = addr_q;
    assign o_sram_we   = we_q;
    assign o_sram_data = data_q;
    assign o_busy      = counting;
    assign o_done      = done_q;
    assign o_bin_idx   = bin_q;
    assign o_wrapped   = wrap_q;
    assign o_overflow  = ovf_q;

endmodule
